// File: rtl/prbs16_pkg.sv
// rtl/prbs16_pkg.sv - shared PRBS16 constants, state type and feedback function
//
// Purpose: single source of the x^16+x^14+x^13+x^11+1 feedback so that the
// pattern generator and prbs16_checker always agree on the sequence.
// Contents:
//    TAP_*              register bit positions feeding the XOR
//    DEF_*              default checker parameters
//    prbs_state_e       checker FSM states
//    prbs16_pred()      next stream bit predicted from the last 16 bits

package prbs16_pkg;

   localparam int PRBS_LEN = 16;

   // r[0] is the newest bit, so the x^16 term is r[15].
   localparam int TAP_A = 15;
   localparam int TAP_B = 13;
   localparam int TAP_C = 12;
   localparam int TAP_D = 10;

   localparam int DEF_LOCK_CNT    = 32;
   localparam int DEF_WINDOW      = 1024;
   localparam int DEF_LOSS_THRESH = 16;
   localparam int DEF_CNT_W       = 32;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } prbs_state_e;

   function automatic logic prbs16_pred(input logic [PRBS_LEN-1:0] r);
      return r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
   endfunction

endpackage

// File: rtl/prbs16_checker.sv
// rtl/prbs16_checker.sv - self-synchronising PRBS16 receive checker
//
// Purpose: fills a 16-bit history from the received stream, locks after
// LOCK_CNT consecutive correct predictions, then free-runs its own copy of
// the sequence and counts mismatches. Lock is dropped when LOSS_THRESH
// errors land inside one WINDOW-bit window.
// Ports:
//    clk        in   rising-edge clock
//    reset      in   synchronous active-high reset
//    enable     in   din carries a valid stream bit this cycle
//    din        in   received stream bit
//    clear_cnt  in   synchronous clear of err_count
//    locked     out  checker is in LOCKED
//    err_pulse  out  previous valid bit mismatched while LOCKED
//    err_count  out  saturating mismatch count (kept across loss of lock)

module prbs16_checker
   import prbs16_pkg::*;
#(
   parameter int LOCK_CNT    = DEF_LOCK_CNT,
   parameter int WINDOW      = DEF_WINDOW,
   parameter int LOSS_THRESH = DEF_LOSS_THRESH,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             din,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count
);

   localparam int MATCH_W = (LOCK_CNT > 1)    ? $clog2(LOCK_CNT)    : 1;
   localparam int WBITS_W = (WINDOW > 1)      ? $clog2(WINDOW)      : 1;
   localparam int WERR_W  = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;
   localparam int FILL_W  = $clog2(PRBS_LEN + 1);

   // Counters only ever hold "events so far minus one" at their terminal
   // value; the terminal event itself triggers the action instead of storing.
   localparam logic [MATCH_W-1:0] LAST_MATCH = MATCH_W'(LOCK_CNT - 1);
   localparam logic [WBITS_W-1:0] LAST_BIT   = WBITS_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0]  LAST_ERR   = WERR_W'(LOSS_THRESH - 1);
   localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(PRBS_LEN);

   prbs_state_e             state_q, state_d;
   logic [PRBS_LEN-1:0]     r_q, r_d;
   logic [FILL_W-1:0]       fill_q, fill_d;
   logic [MATCH_W-1:0]      match_q, match_d;
   logic [WBITS_W-1:0]      wbits_q, wbits_d;
   logic [WERR_W-1:0]       werr_q, werr_d;
   logic                    locked_q, locked_d;
   logic                    err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0]        err_count_q, err_count_d;

   logic                    pred;
   logic                    err_hit;
   logic                    loss;
   logic [CNT_W-1:0]        count_inc;

   assign pred = prbs16_pred(r_q);

   // A counted error is a mismatch on a valid bit while locked.
   assign err_hit = enable && (state_q == LOCKED) && (din != pred);
   assign loss    = err_hit && (werr_q == LAST_ERR);

   assign count_inc = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      fill_d      = fill_q;
      match_d     = match_q;
      wbits_d     = wbits_q;
      werr_d      = werr_q;
      err_pulse_d = err_hit;

      if (enable) begin
         unique case (state_q)
            SEARCH: begin
               r_d = {r_q[PRBS_LEN-2:0], din};
               if (fill_q != FILL_FULL) begin
                  fill_d  = fill_q + FILL_W'(1);
                  match_d = '0;
               end else if ((din == pred) && (r_q != '0)) begin
                  // A zero history predicts zero forever; excluding it
                  // keeps a dead link from ever looking locked.
                  if (match_q == LAST_MATCH) begin
                     state_d = LOCKED;
                     match_d = '0;
                     wbits_d = '0;
                     werr_d  = '0;
                  end else begin
                     match_d = match_q + MATCH_W'(1);
                  end
               end else begin
                  match_d = '0;
               end
            end

            LOCKED: begin
               // Feed back the prediction, not din, so a single flipped
               // bit cannot propagate into later predictions.
               r_d = {r_q[PRBS_LEN-2:0], pred};
               if (loss) begin
                  state_d = SEARCH;
                  fill_d  = '0;
                  match_d = '0;
                  wbits_d = '0;
                  werr_d  = '0;
               end else if (wbits_q == LAST_BIT) begin
                  wbits_d = '0;
                  werr_d  = '0;
               end else begin
                  wbits_d = wbits_q + WBITS_W'(1);
                  werr_d  = werr_q + WERR_W'(err_hit);
               end
            end

            default: state_d = SEARCH;
         endcase
      end

      // Clearing on an error cycle must not lose that error.
      if (clear_cnt) begin
         err_count_d = err_hit ? CNT_W'(1) : '0;
      end else begin
         err_count_d = err_hit ? count_inc : err_count_q;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SEARCH;
         r_q         <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         wbits_q     <= '0;
         werr_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         wbits_q     <= wbits_d;
         werr_q      <= werr_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// tb/tb_prbs16_checker.sv - directed scoreboard bench for prbs16_checker

module tb_prbs16_checker;
   import prbs16_pkg::*;

   typedef struct packed {
      logic        lk;
      logic        pl;
      logic [31:0] cnt;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        din = 1'b0;
   logic        clear_cnt = 1'b0;
   logic        locked;
   logic        err_pulse;
   logic [31:0] err_count;

   int          checks = 0;
   int          errors = 0;

   obs_t        exp_q[$];
   string       tag_q[$];

   logic [15:0] gen;
   logic [31:0] exp_cnt;
   int          lock_bits;
   int          nerr;
   int          valid;

   prbs16_checker dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .din       (din),
      .clear_cnt (clear_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   function automatic logic gen_bit();
      logic b;
      b   = prbs16_pred(gen);
      gen = {gen[14:0], b};
      return b;
   endfunction

   // One clock: drive inputs, push what the outputs must show after the
   // edge, then pop and compare once the edge has been taken.
   task automatic send(input logic rst, input logic en, input logic flip,
                       input logic clr, input logic lk, input logic pl,
                       input logic [31:0] cnt, input string tag);
      obs_t  e;
      obs_t  got;
      string t;
      reset     = rst;
      enable    = en;
      clear_cnt = clr;
      din       = en ? (gen_bit() ^ flip) : 1'($urandom_range(0, 1));
      e.lk  = lk;
      e.pl  = pl;
      e.cnt = cnt;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         got = '{lk: locked, pl: err_pulse, cnt: err_count};
         checks++;
         assert (got === e) else begin
            errors++;
            $error("FAIL %s: observed lk=%b pl=%b cnt=%0d expected lk=%b pl=%b cnt=%0d",
                   t, got.lk, got.pl, got.cnt, e.lk, e.pl, e.cnt);
         end
      end
   endtask

   task automatic relock48(input string tag);
      for (int k = 1; k <= 48; k++)
         send(1'b0, 1'b1, 1'b0, 1'b0, (k == 48), 1'b0, exp_cnt, tag);
      lock_bits = 0;
   endtask

   initial begin
      gen     = 16'h1001;
      exp_cnt = 32'd0;

      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, "reset_state");
      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, "reset_state");

      // All-zero input must never lock.
      for (int i = 0; i < 5000; i++) begin
         reset = 1'b0; enable = 1'b1; clear_cnt = 1'b0; din = 1'b0;
         exp_q.push_back('{lk: 1'b0, pl: 1'b0, cnt: 32'd0});
         tag_q.push_back("zero_nolock");
         @(posedge clk);
         #1;
         begin
            obs_t e;
            obs_t got;
            string t;
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = '{lk: locked, pl: err_pulse, cnt: err_count};
            checks++;
            assert (got === e) else begin
               errors++;
               $error("FAIL %s: observed lk=%b pl=%b cnt=%0d expected lk=%b pl=%b cnt=%0d",
                      t, got.lk, got.pl, got.cnt, e.lk, e.pl, e.cnt);
            end
         end
      end

      // Clean lock from reset, seed 16'h1001: locked after valid bit 48.
      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, "reset_again");
      gen = 16'h1001;
      relock48("clean_lock48");
      for (int i = 0; i < 10000; i++) begin
         send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, "clean_run");
         lock_bits++;
      end

      // Single flipped bit: one pulse, one count, lock held.
      exp_cnt = 32'd1;
      send(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, exp_cnt, "single_err");
      lock_bits++;
      for (int i = 0; i < 200; i++) begin
         send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt, "single_after");
         lock_bits++;
      end

      // clear_cnt alone on a clean bit.
      exp_cnt = 32'd0;
      send(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt, "clear_alone");
      lock_bits++;

      // Align to a window start, then 16 errors inside one window.
      while ((lock_bits % 1024) != 0) begin
         send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt, "align_pad");
         lock_bits++;
      end
      nerr = 0;
      for (int i = 0; i <= 300; i++) begin
         if ((i % 20) == 0) begin
            nerr++;
            exp_cnt = exp_cnt + 32'd1;
            send(1'b0, 1'b1, 1'b1, 1'b0, (nerr < 16), 1'b1, exp_cnt, "loss_err");
         end else begin
            send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt, "loss_clean");
         end
      end

      relock48("relock_after_loss");

      // 15 errors per window over two windows keeps lock.
      for (int i = 0; i < 2048; i++) begin
         int w;
         w = (lock_bits % 1024) + 1;
         if ((w % 64) == 10 && w < 960) begin
            exp_cnt = exp_cnt + 32'd1;
            send(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, exp_cnt, "win15_err");
         end else begin
            send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt, "win15_clean");
         end
         lock_bits++;
      end

      // Clear on the same cycle an error is counted keeps that error.
      exp_cnt = 32'd1;
      send(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, exp_cnt, "clear_collision");
      exp_cnt = 32'd0;
      send(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt, "clear_gap");

      // Build err_count=5, then reset mid-lock on an erroneous bit.
      for (int i = 0; i < 50; i++) begin
         if ((i % 10) == 0) begin
            exp_cnt = exp_cnt + 32'd1;
            send(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, exp_cnt, "pre_reset_err");
         end else begin
            send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt, "pre_reset_clean");
         end
      end
      exp_cnt = 32'd0;
      send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt, "reset_midlock");
      relock48("relock_after_reset");

      // Random enable gaps: lock still lands on valid bit 48.
      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, "reset_gaps");
      gen   = 16'h1001;
      valid = 0;
      for (int c = 0; c < 400; c++) begin
         logic en;
         en = 1'($urandom_range(0, 1));
         if (en) valid++;
         send(1'b0, en, 1'b0, 1'b0, (valid >= 48), 1'b0, 32'd0, "gap_lock");
      end
      if (valid < 60) begin
         errors++;
         $error("FAIL gap_budget: observed %0d valid bits expected at least 60", valid);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prbs16_checker.md
# prbs16_checker

Serial receive-side checker for the 16-bit PRBS stream produced by the team's LFSR pattern generator (polynomial x^16+x^14+x^13+x^11+1). It self-synchronises to the incoming bit stream, declares lock, then counts bit errors against a locally regenerated sequence and drops lock on excessive error density. It sits at the far end of loopback and link-test paths, opposite the generator.

## Interface
- LOCK_CNT, 32: consecutive correct predictions, after a 16-bit fill, needed to declare lock.
- WINDOW, 1024: length of the error-density window, in valid bits.
- LOSS_THRESH, 16: errors within one window that force loss of lock.
- CNT_W, 32: width of err_count.

- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enable  in  1  din is a valid stream bit this cycle.
- din  in  1  received stream bit.
- clear_cnt  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle pulse: the bit sampled last cycle mismatched while LOCKED.
- err_count  out  CNT_W  saturating count of mismatches while LOCKED.

## Operation
- Stream convention: each generator step emits its new feedback bit (new state LSB). Checker register r[15:0] holds the last 16 bits, r[0] newest. Prediction pred = r[15]^r[13]^r[12]^r[10].
- Reset values: state SEARCH, r=0, fill=0, match_cnt=0, win_bits=0, win_err=0, locked=0, err_pulse=0, err_count=0.
- enable=0: no state changes; err_pulse=0 next cycle.
- SEARCH, per valid bit:
  - r <= {r[14:0], din}.
  - fill<16: fill++, match_cnt <= 0.
  - fill==16 and din==pred and r!=0 (pre-shift): match_cnt++. When this is the LOCK_CNT-th consecutive match, go LOCKED, clear win_bits/win_err.
  - Otherwise match_cnt <= 0. All-zero input never locks.
- LOCKED, per valid bit:
  - r <= {r[14:0], pred}: free-running; received bits are not fed back, so one flipped bit gives exactly one error.
  - din!=pred: err_pulse=1, err_count++ (saturates at all-ones), win_err++.
  - win_err reaching LOSS_THRESH (this bit included): go SEARCH immediately, fill=0, match_cnt=0. err_count is kept.
  - Else win_bits++. On the WINDOW-th bit, clear win_bits and win_err.
- clear_cnt: err_count <= 0. If an error is counted in the same cycle, err_count <= 1. The error is not lost.
- reset overrides everything, including in mid-lock.

## Timing
- Every output is registered.
- err_pulse and err_count update on the clock after the erroneous bit is sampled.
- locked rises on the clock after the LOCK_CNT-th matching bit is sampled. From reset with clean contiguous input, that is valid bit 16+LOCK_CNT.
- locked falls on the clock after the LOSS_THRESH-th windowed error is sampled. That same bit still pulses err_pulse and is counted.
- Throughput: one bit per clock. Gaps in enable are transparent; all counts are in valid bits.

## Structure
- prbs16_pkg holds:
  - tap constants: 15, 13, 12, 10.
  - state enum {SEARCH, LOCKED}.
  - function prbs16_pred(r) returning the feedback bit.
  - the default values for LOCK_CNT, WINDOW and LOSS_THRESH.
- The generator should also use prbs16_pred, so the two ends cannot drift.
- No sub-module. A single FSM plus counters is sufficient.

## Test plan
- Clean lock: generator (seed 16'h1001, enable=1) drives din → locked=1 one cycle after valid bit 48; err_count=0 over 10000 further bits.
- Single error: flip one bit after lock → exactly one err_pulse, err_count=1, locked stays 1, no further pulses.
- All-zero input: din=0 for 5000 valid bits → locked never rises.
- Loss and relock: inject 16 errors within 1024 bits → locked falls one cycle after the 16th, err_count=16. Clean input then relocks after 48 valid bits. 15 errors per window keeps lock.
- Clear collision: clear_cnt asserted on the cycle an error is counted → err_count=1. clear_cnt alone → 0. Random enable gaps give the same lock point in valid-bit terms.
- Reset mid-lock: reset pulse while locked with err_count=5 → next cycle locked=0, err_count=0, err_pulse=0. Relock after 48 valid bits.
